cmd_sequencer: RTL
==================

Name: cmd_sequencer

Overview:
- Parametrised successor to the 8x8 command front end.
- Decodes the packed `ui_in` command/parameter stream into complete drawing packets. Coordinate width is generic.
- Completed packets are queued in a small FIFO and presented to the rasterizer over a valid/ready handshake.
- Adds protocol-error and parameter-timeout detection with sticky status flags, plus backpressure when the queue is full.

Parameters:
- COORD_W, 3, coordinate/size field width; legal range 1..5; taken from `param[COORD_W-1:0]`.
- FIFO_DEPTH, 4, number of queued packets; power of two, >=2.
- TIMEOUT, 255, idle cycles allowed between parameter words before abort; >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ui_in  in  8  [7]=en, [6:5]=cmd, [4:0]=param.
- err_clr  in  1  clears the sticky error flags.
- pkt_valid  out  1  FIFO head holds a packet.
- pkt_ready  in  1  rasterizer accepts the head packet.
- pkt_op  out  3  0 NONE, 1 PIXEL, 2 LINE, 3 RECT, 4 CLEAR.
- pkt_x1, pkt_y1, pkt_x2, pkt_y2  out  COORD_W each  coordinates (x2/y2 carry width/height for RECT).
- busy  out  1  assembler not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- err_proto  out  1  sticky: non-NOP word received mid-parameter load.
- err_timeout  out  1  sticky: parameter timeout.

Behaviour:
- Reset: all outputs 0 (`pkt_op` = NONE), FIFO empty, FSM in IDLE, counters 0.
- Input word accepted only when `en`=1. `cmd` 00 = NOP/parameter word. Opcodes: 01 PIXEL, or CLEAR when `param`==5'b11111; 10 LINE; 11 RECT.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - en && cmd=00: ignored.
  - CLEAR: packet complete immediately (op=4, coords 0).
  - PIXEL/LINE/RECT: capture x1, set need = 1 (PIXEL) or 3 (LINE/RECT), go to LOAD.
- LOAD:
  - en && cmd=00: capture the next field in order y1, x2, y2; decrement need; clear timer. The word with need=1 completes the packet.
  - en && cmd!=00: abort, word dropped (not reinterpreted), err_proto<=1, go to IDLE.
  - en=0: timer increments. When timer reaches TIMEOUT: abort, err_timeout<=1, go to IDLE.
- Packet completion:
  - If the FIFO has space (!full, or a pop in the same cycle), the packet is written at that edge and the FSM goes to IDLE.
  - Otherwise the FSM goes to HOLD with the packet registered. `ui_in` is ignored in HOLD. The packet is written on the first cycle with space, then the FSM returns to IDLE.
- Latency: completing word at edge N produces pkt_valid=1 from cycle N+1 when the FIFO was empty.
- Handshake:
  - Pop on pkt_valid && pkt_ready.
  - Head fields are stable while pkt_valid && !pkt_ready.
  - Simultaneous push and pop when full is legal; level is unchanged.
  - Push and pop when empty: the packet enters, head becomes valid next cycle.
- Coordinates: the field is `param[COORD_W-1:0]`; upper bits are ignored except for CLEAR detection. Unused fields are 0 (PIXEL: x2=y2=0).
- Errors: sticky until err_clr. Set and err_clr in the same cycle: set wins.
- Timer: saturating, width $clog2(TIMEOUT+1). It does not run in IDLE or HOLD.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Reset mid-load or in HOLD discards the partial or held packet and flushes the FIFO.

Decomposition:
- Package cmd_seq_pkg:
  - op encodings (OP_NONE..OP_CLEAR).
  - ui_in cmd encodings and the CLEAR sentinel 5'b11111.
  - FSM state constants.
  - packet field order.
- Sub-module pkt_fifo, parametrised by width (3+4*COORD_W) and FIFO_DEPTH. Synchronous FIFO with level output and same-cycle push/pop.

Test Plan:
- PIXEL: ui_in 0xA3, 0x85 -> one cycle later pkt_valid=1, op=1, x1=3, y1=5, x2=y2=0; with pkt_ready=1, level returns to 0.
- RECT with COORD_W=4: 0xE9, 0x82, 0x84, 0x83 -> op=3, x1=9, y1=2, x2=4, y2=3. Then CLEAR 0xBF -> second packet op=4.
- Protocol error: 0xC1, 0x82, 0xA4 -> no packet, err_proto=1, 0xA4 not executed. err_clr pulse -> err_proto=0.
- Timeout with TIMEOUT=4: 0xC1, then en=0 for 4 cycles -> err_timeout=1, busy=0; a following 0x85 is ignored.
- Backpressure with FIFO_DEPTH=2, pkt_ready=0: three CLEAR words -> level=2, busy=1 in HOLD. Raising pkt_ready for one cycle pushes the held packet; level stays 2.
- Reset asserted mid-LINE load with FIFO level 1 -> all outputs 0 immediately, no packet emitted after release.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared encodings for the command sequencer: packet opcodes, ui_in command
// codes, assembler states and the order in which packet fields are loaded.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_PIXEL = 3'd1,
    OP_LINE  = 3'd2,
    OP_RECT  = 3'd3,
    OP_CLEAR = 3'd4
  } op_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_LINE  = 2'b10;
  localparam logic [1:0] CMD_RECT  = 2'b11;

  localparam logic [4:0] CLEAR_SENTINEL = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Packet fields arrive in this order; x1 always rides on the opcode word.
  typedef enum logic [1:0] {
    FLD_X1 = 2'd0,
    FLD_Y1 = 2'd1,
    FLD_X2 = 2'd2,
    FLD_Y2 = 2'd3
  } fld_e;

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous FIFO with occupancy output; a push is accepted when full
// if a pop happens in the same cycle.
module pkt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Assembles ui_in command/parameter words into drawing packets, queues them and
// hands them to the rasterizer; flags protocol errors and parameter timeouts.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int COORD_W    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ui_in,
  input  logic                          err_clr,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [2:0]                    pkt_op,
  output logic [COORD_W-1:0]            pkt_x1,
  output logic [COORD_W-1:0]            pkt_y1,
  output logic [COORD_W-1:0]            pkt_x2,
  output logic [COORD_W-1:0]            pkt_y2,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_proto,
  output logic                          err_timeout
);

  localparam int PW = 3 + 4*COORD_W;
  localparam int TW = $clog2(TIMEOUT+1);

  state_e             state_q;
  op_e                op_q;
  fld_e               fld_q;
  logic [1:0]         need_q;
  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
  logic [TW-1:0]      timer_q;
  logic [PW-1:0]      hold_q;
  logic               err_proto_q, err_timeout_q;

  logic               en, is_clear, load_word, idle_clear, complete;
  logic               space, push, pop, empty, full;
  logic [1:0]         cmd;
  logic [COORD_W-1:0] coord;
  logic [PW-1:0]      pkt_d, push_data, head;
  logic [TW:0]        timer_inc;
  logic               timeout_hit;

  assign en         = ui_in[7];
  assign cmd        = ui_in[6:5];
  assign coord      = ui_in[COORD_W-1:0];
  assign is_clear   = (cmd == CMD_PIXEL) && (ui_in[4:0] == CLEAR_SENTINEL);
  assign load_word  = (state_q == ST_LOAD) && en && (cmd == CMD_NOP);
  assign idle_clear = (state_q == ST_IDLE) && en && is_clear;
  assign complete   = idle_clear || (load_word && need_q == 2'd1);

  assign timer_inc   = {1'b0, timer_q} + 1'b1;
  assign timeout_hit = (timer_inc >= (TW+1)'(TIMEOUT));

  // Packet as it would look with the current word folded into its field.
  always_comb begin
    pkt_d = {op_q, x1_q, y1_q, x2_q, y2_q};
    case (fld_q)
      FLD_Y1:  pkt_d[2*COORD_W +: COORD_W] = coord;
      FLD_X2:  pkt_d[COORD_W +: COORD_W]   = coord;
      FLD_Y2:  pkt_d[0 +: COORD_W]         = coord;
      default: pkt_d = pkt_d;
    endcase
    if (idle_clear) pkt_d = {OP_CLEAR, {(4*COORD_W){1'b0}}};
  end

  assign pop       = pkt_valid && pkt_ready;
  assign space     = !full || pop;
  assign push      = (state_q == ST_HOLD) ? space : (complete && space);
  assign push_data = (state_q == ST_HOLD) ? hold_q : pkt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NONE;
      fld_q         <= FLD_X1;
      need_q        <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      x2_q          <= '0;
      y2_q          <= '0;
      timer_q       <= '0;
      hold_q        <= '0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (err_clr) begin
        err_proto_q   <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (idle_clear) begin
            hold_q <= pkt_d;
            if (!space) state_q <= ST_HOLD;
          end else if (en && cmd != CMD_NOP) begin
            op_q    <= op_e'({1'b0, cmd});
            x1_q    <= coord;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            need_q  <= (cmd == CMD_PIXEL) ? 2'd1 : 2'd3;
            fld_q   <= FLD_Y1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (en && cmd == CMD_NOP) begin
            case (fld_q)
              FLD_Y1:  y1_q <= coord;
              FLD_X2:  x2_q <= coord;
              FLD_Y2:  y2_q <= coord;
              default: ;
            endcase
            fld_q   <= fld_e'(fld_q + 2'd1);
            need_q  <= need_q - 2'd1;
            timer_q <= '0;
            if (complete) begin
              hold_q  <= pkt_d;
              state_q <= space ? ST_IDLE : ST_HOLD;
            end
          end else if (en) begin
            err_proto_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= ST_IDLE;
          end else if (timer_q != TW'(TIMEOUT)) begin
            timer_q <= timer_inc[TW-1:0];
          end
        end
        ST_HOLD: begin
          timer_q <= '0;
          if (space) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pkt_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head),
    .empty     (empty),
    .full      (full),
    .level     (fifo_level)
  );

  // Head RAM is not reset, so fields are forced to zero while nothing is queued.
  assign pkt_valid = !empty;
  assign {pkt_op, pkt_x1, pkt_y1, pkt_x2, pkt_y2} = pkt_valid ? head : '0;

  assign busy        = (state_q != ST_IDLE);
  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;

endmodule
